// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD <-> binary converters: FSM encodings and
// sizing constants, plus a digit-validity helper.
package bcd_to_binary_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int         BCD_DIGITS  = 4;
    localparam int         BCD_ITER    = 16;
    localparam logic [15:0] BCD_MAX_BIN = 16'h270F;

    // True when any packed nibble holds a non-decimal value (A..F).
    function automatic logic has_bad_digit(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_binary_nibble_adjust.sv
// Reverse double-dabble correction for one BCD column: after the right shift,
// a column holding 8 or more is pulled back by 3.
module bcd_nibble_adjust (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd8) ? (i_nib - 4'd3) : i_nib;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential 4-digit packed BCD to 16-bit binary converter (reverse
// double-dabble), one shift per clock behind a start/busy/done handshake.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int DIGITS = BCD_DIGITS,
    parameter int ITER   = BCD_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] binary,
    output logic        err
);

    logic [1:0]  r_state;
    logic [31:0] r_sr;
    logic [3:0]  r_cnt;
    logic        r_bad;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_binary;
    logic        r_err;

    logic [31:0] w_shifted;
    logic [31:0] w_sr_next;

    // Bit 16 falls into bit 15: the BCD field feeds the binary field.
    assign w_shifted        = {1'b0, r_sr[31:1]};
    assign w_sr_next[15:0]  = w_shifted[15:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_nibble_adjust u_adj (
                .i_nib (w_shifted[16 + 4*gi +: 4]),
                .o_nib (w_sr_next[16 + 4*gi +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sr     <= 32'h0;
            r_cnt    <= 4'd0;
            r_bad    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_binary <= 16'h0000;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sr    <= {bcd, 16'h0000};
                        r_cnt   <= 4'd0;
                        r_bad   <= has_bad_digit(bcd);
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt + 4'd1;
                    // Invalid input still runs all iterations to keep latency fixed.
                    if (r_cnt == 4'(ITER - 1)) begin
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_binary <= r_bad ? 16'h0000 : w_sr_next[15:0];
                        r_err    <= r_bad;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign binary = r_binary;
    assign err    = r_err;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: the driver queues expected results at
// acceptance, the monitor checks value, latency, busy length and hold on done.
module tb_bcd_to_binary;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd;
    logic        busy;
    logic        done;
    logic [15:0] binary;
    logic        err;

    typedef struct {
        logic [15:0] bin;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    int          busy_run     = 0;
    bit          hold_pending = 0;
    logic [15:0] hold_bin;
    logic        hold_err;
    bit          sweep_mode   = 0;
    int          last_done    = -1;

    bcd_to_binary dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bcd    (bcd),
        .busy   (busy),
        .done   (done),
        .binary (binary),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) check("busy_and_done", 1, 0);
            if (hold_pending) begin
                hold_pending = 0;
                check("hold_binary", binary, hold_bin);
                check("hold_err", err, hold_err);
            end
            if (busy) busy_run++;
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("binary", binary, e.bin);
                    check("err", err, e.err);
                    check("latency", cyc - e.acc, 16);
                    check("busy_cycles", busy_run, 16);
                    $display("[TB] done: binary=0x%04h err=%0d (expected 0x%04h/%0d)",
                             binary, err, e.bin, e.err);
                    if (sweep_mode && last_done >= 0) check("done_spacing", cyc - last_done, 18);
                    last_done    = cyc;
                    hold_bin     = e.bin;
                    hold_err     = e.err;
                    hold_pending = 1;
                end
                busy_run = 0;
            end
            if (!busy && !done) busy_run = 0;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            $display("FAIL idle_timeout: busy=%0d done=%0d, expected both 0", busy, done);
            fails++;
            $fatal(1, "[TB] DUT never returned to idle");
        end
    endtask

    task automatic convert(input logic [15:0] code, input logic [15:0] exp_bin, input logic exp_err);
        exp_t e;
        wait_idle();
        start = 1'b1;
        bcd   = code;
        @(posedge clk);
        #1;
        e.bin = exp_bin;
        e.err = exp_err;
        e.acc = cyc;
        q.push_back(e);
        start = 1'b0;
        bcd   = 16'hFFFF;
    endtask

    initial begin
        exp_t e;
        int   code;
        rst   = 1'b1;
        start = 1'b0;
        bcd   = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_binary", binary, 0);
        check("reset_err", err, 0);
        rst = 1'b0;

        convert(16'h0000, 16'h0000, 1'b0);
        convert(16'h1234, 16'h04D2, 1'b0);
        convert(16'h9999, 16'h270F, 1'b0);
        convert(16'h12A4, 16'h0000, 1'b1);
        convert(16'h0042, 16'h002A, 1'b0);

        // Start held high with bcd changing after acceptance: the second
        // acceptance lands exactly 18 edges later and uses the new bcd.
        wait_idle();
        start = 1'b1;
        bcd   = 16'h0500;
        @(posedge clk);
        #1;
        e.bin = 16'h01F4; e.err = 1'b0; e.acc = cyc;
        q.push_back(e);
        bcd = 16'h0001;
        repeat (18) @(posedge clk);
        #1;
        e.bin = 16'h0001; e.err = 1'b0; e.acc = cyc;
        q.push_back(e);
        start = 1'b0;

        // Reset at N+8 of a 9999 conversion aborts it with no done pulse.
        wait_idle();
        start = 1'b1;
        bcd   = 16'h9999;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_binary", binary, 0);
        check("abort_err", err, 0);
        rst = 1'b0;

        // Reset and start together: reset wins.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bcd   = 16'h1234;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", busy, 0);

        convert(16'h0777, 16'h0309, 1'b0);

        // Back-to-back sampled sweep of valid codes.
        wait_idle();
        sweep_mode = 1;
        last_done  = -1;
        for (int i = 0; i <= 10000; i += 37) begin
            logic [15:0] packed_bcd;
            code = (i > 9999) ? 9999 : i;
            packed_bcd = {4'(code / 1000), 4'((code / 100) % 10), 4'((code / 10) % 10), 4'(code % 10)};
            convert(packed_bcd, 16'(code), 1'b0);
        end

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("queue_drained", q.size(), 0);
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
